shim_ads816x_conv_scheduler: RTL and testbench

SHIM_ADS816X_CONV_SCHEDULER -- requirements
Module: shim_ads816x_conv_scheduler

---
 rtl/shim_ads816x_conv_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_shim_ads816x_conv_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shim_ads816x_conv_scheduler.sv
// Conversion scheduler for the ADS816x shim. It sequences the timing calculator and walks
// the channel mask one SPI transfer at a time, holding n_cs high between transfers.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_OFF       | disabled; sticky flags cleared
// S_CALC      | calc asserted, waiting for timing result or lock violation
// S_RECALC    | one-cycle calc drop, re-latch SPI frequency
// S_IDLE      | configured, waiting for trigger
// S_ISSUE     | conversion command offered to the SPI shifter
// S_WAIT_XFER | waiting for the SPI transfer to complete
// S_GAP       | enforcing n_cs high time after a transfer
module shim_ads816x_conv_scheduler #(
  parameter int N_CH = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  input  logic [31:0]     spi_clk_freq_hz,
  output logic            calc,
  input  logic            calc_done,
  input  logic            calc_lock_viol,
  input  logic [7:0]      n_cs_high_time_in,
  input  logic            trigger,
  input  logic [N_CH-1:0] ch_mask,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [2:0]      cmd_channel,
  output logic            cmd_last,
  input  logic            xfer_done,
  output logic            ready,
  output logic            busy,
  output logic            sweep_done,
  output logic [7:0]      n_cs_high_time,
  output logic            overrun,
  output logic            freq_err
);

  typedef enum logic [2:0] {
    S_OFF,
    S_CALC,
    S_RECALC,
    S_IDLE,
    S_ISSUE,
    S_WAIT_XFER,
    S_GAP
  } state_t;

  localparam logic [N_CH-1:0] MASK_ONE = {{(N_CH-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [31:0]     freq_lat_q, freq_lat_d;
  logic [7:0]      n_cs_q, n_cs_d;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [2:0]      cmd_channel_q, cmd_channel_d;
  logic            cmd_last_q, cmd_last_d;
  logic            sweep_done_q, sweep_done_d;
  logic            overrun_q, overrun_d;
  logic            freq_err_q, freq_err_d;
  logic            abort_q, abort_d;

  logic            freq_chg;
  logic            in_sweep;
  logic [N_CH-1:0] trig_rest;
  logic [N_CH-1:0] pend_rest;
  logic [7:0]      gap_load;

  function automatic logic [2:0] lowest_ch(input logic [N_CH-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // pend_q holds the channels still to be issued after the one currently in flight;
  // m & (m - 1) drops the lowest set bit, which is always the channel just scheduled.
  assign freq_chg  = (spi_clk_freq_hz != freq_lat_q);
  assign in_sweep  = (state_q == S_ISSUE) || (state_q == S_WAIT_XFER) || (state_q == S_GAP);
  assign trig_rest = ch_mask & (ch_mask - MASK_ONE);
  assign pend_rest = pend_q & (pend_q - MASK_ONE);
  assign gap_load  = (n_cs_q == 8'd0) ? 8'd1 : n_cs_q;

  always_comb begin
    state_d       = state_q;
    freq_lat_d    = freq_lat_q;
    n_cs_d        = n_cs_q;
    gap_cnt_d     = gap_cnt_q;
    pend_d        = pend_q;
    cmd_channel_d = cmd_channel_q;
    cmd_last_d    = cmd_last_q;
    sweep_done_d  = 1'b0;
    overrun_d     = overrun_q;
    freq_err_d    = freq_err_q;
    abort_d       = abort_q;

    if (!enable) begin
      state_d       = S_OFF;
      n_cs_d        = '0;
      gap_cnt_d     = '0;
      pend_d        = '0;
      cmd_channel_d = '0;
      cmd_last_d    = 1'b0;
      overrun_d     = 1'b0;
      freq_err_d    = 1'b0;
      abort_d       = 1'b0;
    end else begin
      if (trigger && (state_q != S_IDLE)) overrun_d = 1'b1;
      if (in_sweep && freq_chg) begin
        freq_err_d = 1'b1;
        abort_d    = 1'b1;
      end

      unique case (state_q)
        S_OFF: begin
          overrun_d  = 1'b0;
          freq_err_d = 1'b0;
          freq_lat_d = spi_clk_freq_hz;
          state_d    = S_CALC;
        end
        S_CALC: begin
          // a lock violation means the result is stale, so it wins over calc_done
          if (calc_lock_viol) begin
            state_d = S_RECALC;
          end else if (calc_done) begin
            n_cs_d  = n_cs_high_time_in;
            state_d = S_IDLE;
          end
        end
        S_RECALC: begin
          freq_lat_d = spi_clk_freq_hz;
          state_d    = S_CALC;
        end
        S_IDLE: begin
          if (freq_chg) begin
            if (trigger) overrun_d = 1'b1;
            state_d = S_RECALC;
          end else if (trigger) begin
            if (ch_mask == '0) begin
              sweep_done_d = 1'b1;
            end else begin
              cmd_channel_d = lowest_ch(ch_mask);
              pend_d        = trig_rest;
              cmd_last_d    = (trig_rest == '0);
              abort_d       = 1'b0;
              state_d       = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (cmd_ready) state_d = S_WAIT_XFER;
        end
        S_WAIT_XFER: begin
          if (xfer_done) begin
            gap_cnt_d = gap_load;
            state_d   = S_GAP;
          end
        end
        S_GAP: begin
          gap_cnt_d = gap_cnt_q - 8'd1;
          if (gap_cnt_q <= 8'd1) begin
            gap_cnt_d = '0;
            if (abort_q || freq_chg) begin
              abort_d = 1'b0;
              state_d = S_RECALC;
            end else if (pend_q == '0) begin
              sweep_done_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              cmd_channel_d = lowest_ch(pend_q);
              pend_d        = pend_rest;
              cmd_last_d    = (pend_rest == '0);
              state_d       = S_ISSUE;
            end
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_OFF;
      freq_lat_q    <= '0;
      n_cs_q        <= '0;
      gap_cnt_q     <= '0;
      pend_q        <= '0;
      cmd_channel_q <= '0;
      cmd_last_q    <= 1'b0;
      sweep_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      freq_err_q    <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      freq_lat_q    <= freq_lat_d;
      n_cs_q        <= n_cs_d;
      gap_cnt_q     <= gap_cnt_d;
      pend_q        <= pend_d;
      cmd_channel_q <= cmd_channel_d;
      cmd_last_q    <= cmd_last_d;
      sweep_done_q  <= sweep_done_d;
      overrun_q     <= overrun_d;
      freq_err_q    <= freq_err_d;
      abort_q       <= abort_d;
    end
  end

  assign calc           = (state_q == S_CALC);
  assign cmd_valid      = (state_q == S_ISSUE);
  assign ready          = (state_q == S_IDLE);
  assign busy           = in_sweep;
  assign cmd_channel    = cmd_channel_q;
  assign cmd_last       = cmd_last_q;
  assign sweep_done     = sweep_done_q;
  assign n_cs_high_time = n_cs_q;
  assign overrun        = overrun_q;
  assign freq_err       = freq_err_q;

endmodule

// File: tb/tb_shim_ads816x_conv_scheduler.sv
// Bench for the conversion scheduler: directed stimulus pushes expected commands into a
// scoreboard; a monitor pops and compares on every cycle cmd_valid is high.
module tb_shim_ads816x_conv_scheduler;

  localparam int N_CH = 8;

  logic            clk = 1'b0;
  logic            resetn, enable, calc, calc_done, calc_lock_viol, trigger;
  logic            cmd_valid, cmd_ready, cmd_last, xfer_done;
  logic            ready, busy, sweep_done, overrun, freq_err;
  logic [31:0]     freq;
  logic [7:0]      n_cs_in, n_cs;
  logic [N_CH-1:0] ch_mask;
  logic [2:0]      cmd_channel;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int sweep_cnt = 0;
  int xfer_timer = 0;
  int last_xfer_cyc = -1;
  int gap_exp = 34;
  bit auto_xfer = 1'b1;
  bit gap_chk = 1'b0;
  bit prev_valid = 1'b0;
  logic [3:0] exp_q[$];

  shim_ads816x_conv_scheduler #(.N_CH(N_CH)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .enable            (enable),
    .spi_clk_freq_hz   (freq),
    .calc              (calc),
    .calc_done         (calc_done),
    .calc_lock_viol    (calc_lock_viol),
    .n_cs_high_time_in (n_cs_in),
    .trigger           (trigger),
    .ch_mask           (ch_mask),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_channel       (cmd_channel),
    .cmd_last          (cmd_last),
    .xfer_done         (xfer_done),
    .ready             (ready),
    .busy              (busy),
    .sweep_done        (sweep_done),
    .n_cs_high_time    (n_cs),
    .overrun           (overrun),
    .freq_err          (freq_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input bit last);
    logic [2:0] c;
    c = 3'(ch);
    exp_q.push_back({last, c});
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return ready === 1'b1;
      1:       return calc === 1'b1;
      2:       return busy === 1'b0;
      3:       return exp_q.size() == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int budget, input string nm);
    int k;
    k = 0;
    while (!cond(sel) && k < budget) begin
      step(1);
      k++;
    end
    n_cmp++;
    if (!cond(sel)) begin
      n_fail++;
      $display("FAIL %s: condition not reached within %0d cycles", nm, budget);
    end
  endtask

  // Monitor and SPI shifter model share one process so xfer_done timing follows accepts.
  task automatic monitor();
    forever begin
      @(negedge clk);
      xfer_done = 1'b0;
      if (xfer_timer > 0) begin
        xfer_timer--;
        if (xfer_timer == 0) begin
          xfer_done = 1'b1;
          if (gap_chk) last_xfer_cyc = cyc + 1;
        end
      end
      if (cmd_valid && !prev_valid && gap_chk && last_xfer_cyc >= 0) begin
        check("gap_cycles", 32'(cyc - last_xfer_cyc), 32'(gap_exp));
        last_xfer_cyc = -1;
      end
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_cmd: got channel %0d last %0d, expected no command",
                   cmd_channel, cmd_last);
        end else begin
          check("cmd_last_channel", {28'd0, cmd_last, cmd_channel}, {28'd0, exp_q[0]});
        end
        if (cmd_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (auto_xfer) xfer_timer = 20;
        end
      end
      if (sweep_done) begin
        sweep_cnt++;
        last_xfer_cyc = -1;
      end
      prev_valid = cmd_valid;
    end
  endtask

  initial begin
    resetn = 0; enable = 0; freq = 50_000_000; calc_done = 0; calc_lock_viol = 0;
    n_cs_in = 0; trigger = 0; ch_mask = '0; cmd_ready = 0; xfer_done = 0;
    fork
      monitor();
    join_none
    step(3);
    check("rst_calc", calc, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_freq_err", freq_err, 0);
    check("rst_n_cs", n_cs, 0);
    check("rst_cmd_channel", cmd_channel, 0);
    check("rst_cmd_last", cmd_last, 0);

    // Bring-up and timing calculation
    resetn = 1; step(2);
    check("off_calc_low", calc, 0);
    enable = 1; step(1);
    check("calc_asserted", calc, 1);
    n_cs_in = 34; step(3);
    check("calc_held", calc, 1);
    check("not_ready_in_calc", ready, 0);
    calc_done = 1; step(1); calc_done = 0; n_cs_in = 0;
    check("ready_after_calc", ready, 1);
    check("calc_drop", calc, 0);
    check("n_cs_latched", n_cs, 34);

    // Sweep over channels 0, 2, 7 with a mid-sweep trigger
    ch_mask = 8'b1000_0101; cmd_ready = 1; gap_chk = 1; gap_exp = 34;
    push(0, 0); push(2, 0); push(7, 1);
    trigger = 1; step(1); trigger = 0;
    check("busy_in_sweep", busy, 1);
    check("ready_low_in_sweep", ready, 0);
    step(5);
    trigger = 1; step(1); trigger = 0;
    check("overrun_mid_sweep", overrun, 1);
    wait_until(2, 400, "sweep_a_end");
    step(1);
    check("sweep_a_done_count", sweep_cnt, 1);
    check("sweep_a_all_issued", exp_q.size(), 0);
    gap_chk = 0;

    // Backpressure: command must hold while cmd_ready is low
    ch_mask = 8'b0001_0000; cmd_ready = 0;
    push(4, 1);
    trigger = 1; step(1); trigger = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", cmd_valid, 1);
      check("stall_channel", cmd_channel, 4);
      check("stall_last", cmd_last, 1);
      step(1);
    end
    cmd_ready = 1; step(1); cmd_ready = 0;
    check("valid_drop_after_accept", cmd_valid, 0);
    wait_until(2, 200, "stall_sweep_end");
    step(1);
    check("stall_done_count", sweep_cnt, 2);

    // Empty mask: immediate sweep_done, no command
    ch_mask = '0;
    trigger = 1; step(1); trigger = 0;
    check("zero_mask_done", sweep_done, 1);
    check("zero_mask_no_cmd", cmd_valid, 0);
    check("zero_mask_not_busy", busy, 0);
    step(1);
    check("zero_mask_done_pulse", sweep_done, 0);
    check("zero_mask_done_count", sweep_cnt, 3);

    // Frequency change during channel 2
    ch_mask = 8'b1000_0101; cmd_ready = 1;
    push(0, 0); push(2, 0);
    trigger = 1; step(1); trigger = 0;
    wait_until(3, 300, "ch2_accepted");
    freq = 25_000_000; step(2);
    check("freq_err_set", freq_err, 1);
    wait_until(2, 200, "abort_gap_end");
    check("recalc_calc_low", calc, 0);
    check("abort_no_done", sweep_done, 0);
    check("abort_not_ready", ready, 0);
    step(1);
    check("recalc_calc_high", calc, 1);
    check("abort_done_count", sweep_cnt, 3);

    // Lock violation retry, then zero n_cs gives a one-cycle gap
    calc_lock_viol = 1; step(1); calc_lock_viol = 0;
    check("lock_viol_drop", calc, 0);
    step(1);
    check("lock_viol_retry", calc, 1);
    calc_done = 1; step(1); calc_done = 0;
    check("ready_after_retry", ready, 1);
    check("n_cs_zero", n_cs, 0);
    check("freq_err_sticky", freq_err, 1);
    check("overrun_sticky", overrun, 1);
    ch_mask = 8'b0000_0011; gap_chk = 1; gap_exp = 1;
    push(0, 0); push(1, 1);
    trigger = 1; step(1); trigger = 0;
    wait_until(2, 200, "min_gap_sweep_end");
    step(1);
    check("min_gap_done_count", sweep_cnt, 4);
    gap_chk = 0;

    // enable dropped while waiting for the transfer
    ch_mask = 8'b0000_0010; auto_xfer = 0;
    push(1, 1);
    trigger = 1; step(1); trigger = 0;
    wait_until(3, 50, "en_cmd_accepted");
    step(2);
    enable = 0; step(1);
    check("dis_calc", calc, 0);
    check("dis_cmd_valid", cmd_valid, 0);
    check("dis_ready", ready, 0);
    check("dis_busy", busy, 0);
    check("dis_sweep_done", sweep_done, 0);
    check("dis_overrun", overrun, 0);
    check("dis_freq_err", freq_err, 0);
    check("dis_cmd_channel", cmd_channel, 0);
    check("dis_cmd_last", cmd_last, 0);
    step(1);

    freq = 40_000_000; enable = 1; step(1);
    check("reenable_calc", calc, 1);
    n_cs_in = 5; calc_done = 1; step(1); calc_done = 0;
    check("reenable_ready", ready, 1);
    check("reenable_n_cs", n_cs, 5);

    // Asynchronous reset while waiting for the transfer
    ch_mask = 8'b0000_1000;
    push(3, 1);
    trigger = 1; step(1); trigger = 0;
    wait_until(3, 50, "rst_cmd_accepted");
    step(2);
    #2 resetn = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cmd_valid", cmd_valid, 0);
    check("arst_calc", calc, 0);
    check("arst_n_cs", n_cs, 0);
    check("arst_cmd_channel", cmd_channel, 0);
    step(2);
    resetn = 1; step(1);
    check("post_rst_calc", calc, 1);
    check("final_done_count", sweep_cnt, 4);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
